qpsk_rx_slicer: RTL and testbench

- Downstream receive stage for one QPSK rail.
- Consumes the 8-bit signed (Q1.7) sample stream produced by the transmit shaping filter (after the channel): one sample per clk, UPSAMPLE samples per symbol.
- Estimates the best sampling phase by per-phase magnitude energy over a window of symbols, decimates at that phase (or a manually forced one) and slices each kept sample to a hard bit.
- Output feeds the BER checker.

---
 rtl/qpsk_rx_slicer_if.sv | 25 ++
 rtl/qpsk_rx_slicer.sv | 133 +++++++++++++
 tb/tb_qpsk_rx_slicer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/qpsk_rx_slicer_if.sv
// rtl/qpsk_rx_slicer_if.sv - sample input, phase control and decision outputs of qpsk_rx_slicer
interface qpsk_rx_slicer_if #(
    parameter int UPSAMPLE = 4,
    parameter int IN_NBITS = 8
);
    localparam int PH_NBITS = $clog2(UPSAMPLE);

    logic signed [IN_NBITS-1:0] rx_in;
    logic                       phase_auto;
    logic [PH_NBITS-1:0]        phase_man;
    logic                       rx_bit;
    logic                       rx_valid;
    logic [PH_NBITS-1:0]        phase_out;
    logic                       lock;

    modport master (
        output rx_in, phase_auto, phase_man,
        input  rx_bit, rx_valid, phase_out, lock
    );

    modport slave (
        input  rx_in, phase_auto, phase_man,
        output rx_bit, rx_valid, phase_out, lock
    );
endinterface

// File: rtl/qpsk_rx_slicer.sv
// rtl/qpsk_rx_slicer.sv - QPSK rail slicer with energy-based sampling phase estimation
module qpsk_rx_slicer #(
    parameter int UPSAMPLE = 4,
    parameter int IN_NBITS = 8,
    parameter int WIN_LOG2 = 10
) (
    input logic            clk,
    input logic            rst,
    qpsk_rx_slicer_if.slave io
);
    localparam int PH_NBITS  = $clog2(UPSAMPLE);
    localparam int MAG_NBITS = IN_NBITS - 1;
    localparam int ACC_NBITS = IN_NBITS - 1 + WIN_LOG2;
    localparam logic [PH_NBITS-1:0] LAST_PH = PH_NBITS'(UPSAMPLE - 1);

    typedef enum logic [1:0] {ACQ, EVAL, TRACK} state_t;
    state_t state_q, state_d;

    logic [PH_NBITS-1:0]  cnt;
    logic [WIN_LOG2-1:0]  sym_cnt;
    logic [ACC_NBITS-1:0] acc     [UPSAMPLE];
    logic [ACC_NBITS-1:0] snap    [UPSAMPLE];
    logic [ACC_NBITS-1:0] acc_sum [UPSAMPLE];
    logic [MAG_NBITS-1:0] mag;
    logic [PH_NBITS-1:0]  argmax_idx;
    logic [PH_NBITS-1:0]  best_phase;
    logic [PH_NBITS-1:0]  phase_q;
    logic                 frame_end;
    logic                 win_end;
    logic                 lock_q;
    logic                 eval_now;
    logic                 decide;

    // The most negative code has no positive twin; clamp it to full scale.
    always_comb begin
        if (io.rx_in[IN_NBITS-1] && (io.rx_in[MAG_NBITS-1:0] == '0))
            mag = '1;
        else if (io.rx_in[IN_NBITS-1])
            mag = ~io.rx_in[MAG_NBITS-1:0] + MAG_NBITS'(1);
        else
            mag = io.rx_in[MAG_NBITS-1:0];
    end

    assign frame_end = (cnt == LAST_PH);
    assign win_end   = frame_end && (&sym_cnt);
    assign decide    = (cnt == phase_q) && (lock_q || !io.phase_auto);

    always_comb begin
        for (int k = 0; k < UPSAMPLE; k++)
            acc_sum[k] = acc[k] + ((cnt == PH_NBITS'(k)) ? ACC_NBITS'(mag) : '0);
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        logic [ACC_NBITS-1:0] best_val;
        argmax_idx = '0;
        best_val   = snap[0];
        for (int k = 1; k < UPSAMPLE; k++) begin
            if (snap[k] > best_val) begin
                best_val   = snap[k];
                argmax_idx = PH_NBITS'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            sym_cnt <= '0;
            for (int k = 0; k < UPSAMPLE; k++) begin
                acc[k]  <= '0;
                snap[k] <= '0;
            end
        end else begin
            cnt <= cnt + PH_NBITS'(1);
            if (frame_end)
                sym_cnt <= sym_cnt + WIN_LOG2'(1);
            for (int k = 0; k < UPSAMPLE; k++) begin
                if (win_end) begin
                    snap[k] <= acc_sum[k];
                    acc[k]  <= '0;
                end else begin
                    acc[k]  <= acc_sum[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ACQ;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACQ:     if (win_end) state_d = EVAL;
            EVAL:    state_d = TRACK;
            TRACK:   if (win_end) state_d = EVAL;
            default: state_d = ACQ;
        endcase
    end

    always_comb begin
        eval_now = (state_q == EVAL);
        io.lock  = lock_q;
    end

    assign io.phase_out = phase_q;

    // Phase only moves on a frame boundary, so each frame sees exactly one decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_phase  <= '0;
            lock_q      <= 1'b0;
            phase_q     <= '0;
            io.rx_valid <= 1'b0;
            io.rx_bit   <= 1'b0;
        end else begin
            if (eval_now) begin
                best_phase <= argmax_idx;
                lock_q     <= 1'b1;
            end
            if (frame_end)
                phase_q <= io.phase_auto ? best_phase : io.phase_man;
            io.rx_valid <= decide;
            if (decide)
                io.rx_bit <= ~io.rx_in[IN_NBITS-1];
        end
    end
endmodule

// File: tb/tb_qpsk_rx_slicer.sv
// tb/tb_qpsk_rx_slicer.sv - scoreboard bench for qpsk_rx_slicer
module tb_qpsk_rx_slicer;
    localparam int U  = 4;
    localparam int NB = 8;
    localparam int WL = 4;

    typedef struct {
        int   cyc;
        logic bit_v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    qpsk_rx_slicer_if #(.UPSAMPLE(U), .IN_NBITS(NB)) io ();

    qpsk_rx_slicer #(.UPSAMPLE(U), .IN_NBITS(NB), .WIN_LOG2(WL)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Monitor: every rx_valid must match the oldest pending decision.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (io.rx_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_rx_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("valid_cycle", cyc, e.cyc);
                    check("rx_bit", int'(io.rx_bit), int'(e.bit_v));
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                check("missing_rx_valid", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic step(input int s, input bit decide);
        exp_t e;
        io.rx_in = NB'(s);
        if (decide) begin
            e.cyc   = cyc + 1;
            e.bit_v = (s >= 0);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            io.rx_in = NB'($urandom);
            @(posedge clk);
            #1;
            check("rst_rx_valid", int'(io.rx_valid), 0);
            check("rst_rx_bit", int'(io.rx_bit), 0);
            check("rst_phase_out", int'(io.phase_out), 0);
            check("rst_lock", int'(io.lock), 0);
        end
        q.delete();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int cn;
        int s;
        int amp;
        int big;

        io.rx_in      = '0;
        io.phase_auto = 1'b0;
        io.phase_man  = 2'd2;
        #2;

        // Reset values while random samples are applied
        do_reset(3);

        // Manual phase 2: cycle 0 still decides at phase 0, then cnt==2 each frame
        for (int c = 0; c < 24; c++) begin
            cn = c % U;
            s  = (cn == 2) ? ((((c / U) % 2) == 0) ? 64 : -64) : 0;
            step(s, (c < U) ? (cn == 0) : (cn == 2));
            if (cyc == 3) check("man_phase_before", int'(io.phase_out), 0);
            if (cyc == 4) check("man_phase_after", int'(io.phase_out), 2);
        end
        check("man_drained", q.size(), 0);

        // Auto acquire on phase 3, then retrack to phase 1 in the second window
        do_reset(2);
        io.phase_auto = 1'b1;
        io.phase_man  = 2'd2;
        for (int c = 0; c < 152; c++) begin
            cn  = c % U;
            big = (c < 64) ? 3 : 1;
            amp = (cn == big) ? 100 : 10;
            s   = ((((c / U) + cn) % 3) == 0) ? -amp : amp;
            step(s, ((c >= 68) && (c < 132) && (cn == 3)) || ((c >= 132) && (cn == 1)));
            if (cyc == 64)  check("acq_lock_eval", int'(io.lock), 0);
            if (cyc == 65)  check("acq_lock_rise", int'(io.lock), 1);
            if (cyc == 67)  check("acq_phase_hold", int'(io.phase_out), 0);
            if (cyc == 68)  check("acq_phase_3", int'(io.phase_out), 3);
            if (cyc == 128) check("retrack_lock_eval", int'(io.lock), 1);
            if (cyc == 131) check("retrack_phase_hold", int'(io.phase_out), 3);
            if (cyc == 132) check("retrack_phase_1", int'(io.phase_out), 1);
        end
        check("auto_drained", q.size(), 0);

        // Full-scale negative tie, then zeros
        do_reset(1);
        for (int c = 0; c < 140; c++) begin
            cn = c % U;
            s  = (c < 96) ? -128 : 0;
            step(s, (c >= 68) && (cn == 0));
            if (cyc == 65)  check("tie_lock", int'(io.lock), 1);
            if (cyc == 68)  check("tie_phase_0", int'(io.phase_out), 0);
            if (cyc == 136) check("tie_phase_0_w2", int'(io.phase_out), 0);
        end
        check("tie_drained", q.size(), 0);

        // Saturated -128 (127 per sample) must beat +126
        do_reset(1);
        for (int c = 0; c < 80; c++) begin
            cn = c % U;
            s  = (cn == 0) ? 126 : ((cn == 2) ? -128 : 0);
            step(s, (c >= 70) && (cn == 2));
            if (cyc == 68) check("sat_phase_2", int'(io.phase_out), 2);
        end
        check("sat_drained", q.size(), 0);

        // Reset at symbol 10 discards the partial window
        do_reset(1);
        for (int c = 0; c < 40; c++)
            step(((c % U) == 0) ? 50 : -50, 1'b0);
        check("mid_lock_before", int'(io.lock), 0);
        do_reset(2);
        for (int c = 0; c < 72; c++) begin
            step(0, (c >= 68) && ((c % U) == 0));
            if (cyc == 64) check("mid_lock_64", int'(io.lock), 0);
            if (cyc == 65) check("mid_lock_65", int'(io.lock), 1);
        end
        check("mid_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
